// File: rtl/lfsr_keystream_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_keystream_ctrl_if
//  Description : Keystream word channel between the LFSR keystream
//                controller (source) and its consumer (sink). The channel
//                is a plain valid/ready handshake. A word transfers on any
//                rising edge where both word_valid and word_ready are high.
//  Signals     : word_data  [WIDTH] packed keystream word    (source -> sink)
//                word_valid          word_data is valid      (source -> sink)
//                word_ready          sink accepts the word   (sink -> source)
//  Revision    : 1.0  initial release
// ============================================================================
interface lfsr_keystream_ctrl_if #(
    parameter int WIDTH = 8
) ();

    logic [WIDTH-1:0] word_data;
    logic             word_valid;
    logic             word_ready;

    modport master (
        output word_data,
        output word_valid,
        input  word_ready
    );

    modport slave (
        input  word_data,
        input  word_valid,
        output word_ready
    );

endinterface
`default_nettype wire

// File: rtl/lfsr_keystream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_keystream_ctrl
//  Description : Sequencing controller for an external LFSR keystream
//                generator. It seeds the LFSR, discards a warm-up run, and
//                packs the serial LFSR output MSB-first into WIDTH-bit
//                words. Words go out over a valid/ready channel. Reseeds
//                happen on request or every RESEED_PERIOD accepted words.
//  Parameters  : WIDTH          bits per output word (>= 1)
//                SEED_W         LFSR state / seed width
//                WARMUP         LFSR steps discarded after every load (0 ok)
//                RESEED_PERIOD  words between automatic reseeds, 0 = never
//  Ports       : clk         clock, rising edge
//                rst         synchronous reset, active low
//                start       begin operation (only looked at while idle)
//                stop        abort to idle from any active state
//                seed        seed, sampled on start and on every reseed
//                reseed_req  single-cycle reseed request
//                lfsr_load   one-cycle parallel-load strobe to the LFSR
//                lfsr_seed   value the LFSR loads on lfsr_load
//                lfsr_en     LFSR advance enable (bit captured same edge)
//                lfsr_bit    current LFSR output bit
//                busy        controller is not idle
//                word_count  accepted words since reset, wraps at 16 bits
//                word        keystream word channel (master side)
//  Revision    : 1.0  initial release
// ============================================================================
module lfsr_keystream_ctrl #(
    parameter int WIDTH         = 8,
    parameter int SEED_W        = 16,
    parameter int WARMUP        = 32,
    parameter int RESEED_PERIOD = 1024
) (
    input  wire                  clk,
    input  wire                  rst,
    input  wire                  start,
    input  wire                  stop,
    input  wire [SEED_W-1:0]     seed,
    input  wire                  reseed_req,
    output logic                 lfsr_load,
    output logic [SEED_W-1:0]    lfsr_seed,
    output logic                 lfsr_en,
    input  wire                  lfsr_bit,
    output logic                 busy,
    output logic [15:0]          word_count,
    lfsr_keystream_ctrl_if.master word
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    // One down-counter-free step counter serves both warm-up and fill, so
    // it is sized for whichever run is longer.
    localparam int c_cnt_max = (WARMUP > WIDTH) ? WARMUP : WIDTH;
    localparam int c_cnt_w   = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;
    localparam int c_per_w   = (RESEED_PERIOD > 1) ? $clog2(RESEED_PERIOD + 1) : 1;

    localparam logic [c_cnt_w-1:0] c_warm_last = c_cnt_w'((WARMUP > 0) ? (WARMUP - 1) : 0);
    localparam logic [c_cnt_w-1:0] c_fill_last = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
    localparam logic [c_per_w-1:0] c_period    = c_per_w'(RESEED_PERIOD);
    localparam logic [c_per_w-1:0] c_per_one   = c_per_w'(1);
    localparam logic [SEED_W-1:0]  c_seed_one  = SEED_W'(1);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_WARMUP = 3'd2,
        S_FILL   = 3'd3,
        S_HOLD   = 3'd4
    } state_t;

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_per_w-1:0]   r_period;
    logic                 r_pending;

    logic [SEED_W-1:0]    w_seed_fixed;
    logic [c_per_w-1:0]   w_period_inc;
    logic                 w_period_hit;
    logic                 w_handshake;
    logic [WIDTH-1:0]     w_word_next;

    // An all-zero seed would lock the LFSR up, so it is promoted to 1.
    assign w_seed_fixed = (seed == '0) ? c_seed_one : seed;

    // Period count after the current handshake is taken into account.
    assign w_period_inc = r_period + c_per_one;
    assign w_period_hit = (RESEED_PERIOD != 0) && (w_period_inc == c_period);

    assign w_handshake  = word.word_valid && word.word_ready;

    // ------------------------------------------------------------------
    // Bit packer: the first captured bit ends up in the word MSB. Only
    // WIDTH-1 bits need to be stored; the last bit is taken straight from
    // lfsr_bit when the word is registered.
    // ------------------------------------------------------------------
    generate
        if (WIDTH > 1) begin : g_shift
            logic [WIDTH-2:0] r_shift;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_shift <= '0;
                end else if (lfsr_en && (r_state == S_FILL)) begin
                    r_shift <= w_word_next[WIDTH-2:0];
                end
            end

            assign w_word_next = {r_shift, lfsr_bit};
        end else begin : g_shift_single
            assign w_word_next = lfsr_bit;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Sequencer. All controller outputs are registered here together with
    // the state, so lfsr_load / lfsr_en / word_valid / busy are glitch-free
    // and line up with the state they belong to.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state          <= S_IDLE;
            r_cnt            <= '0;
            r_period         <= '0;
            r_pending        <= 1'b0;
            lfsr_load        <= 1'b0;
            lfsr_en          <= 1'b0;
            lfsr_seed        <= '0;
            busy             <= 1'b0;
            word_count       <= '0;
            word.word_data   <= '0;
            word.word_valid  <= 1'b0;
        end else if ((r_state != S_IDLE) && stop) begin
            // Abort wins over everything, including a handshake in the
            // same cycle: the held word is dropped and not counted.
            r_state          <= S_IDLE;
            r_cnt            <= '0;
            r_pending        <= 1'b0;
            lfsr_load        <= 1'b0;
            lfsr_en          <= 1'b0;
            busy             <= 1'b0;
            word.word_valid  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // reseed_req is deliberately not looked at while idle.
                    if (start) begin
                        lfsr_seed <= w_seed_fixed;
                        lfsr_load <= 1'b1;
                        busy      <= 1'b1;
                        r_state   <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    // The load in progress already uses a fresh seed, so a
                    // request arriving in this cycle is absorbed by it.
                    lfsr_load <= 1'b0;
                    lfsr_en   <= 1'b1;
                    r_pending <= 1'b0;
                    r_period  <= '0;
                    r_cnt     <= '0;
                    r_state   <= (WARMUP == 0) ? S_FILL : S_WARMUP;
                end

                S_WARMUP: begin
                    r_pending <= r_pending | reseed_req;
                    if (r_cnt == c_warm_last) begin
                        r_cnt   <= '0;
                        r_state <= S_FILL;
                    end else begin
                        r_cnt   <= r_cnt + c_cnt_one;
                    end
                end

                S_FILL: begin
                    r_pending <= r_pending | reseed_req;
                    if (r_cnt == c_fill_last) begin
                        r_cnt           <= '0;
                        lfsr_en         <= 1'b0;
                        word.word_data  <= w_word_next;
                        word.word_valid <= 1'b1;
                        r_state         <= S_HOLD;
                    end else begin
                        r_cnt           <= r_cnt + c_cnt_one;
                    end
                end

                S_HOLD: begin
                    if (w_handshake) begin
                        word.word_valid <= 1'b0;
                        word_count      <= word_count + 16'd1;
                        r_period        <= w_period_inc;
                        if (r_pending || w_period_hit) begin
                            lfsr_seed <= w_seed_fixed;
                            lfsr_load <= 1'b1;
                            r_pending <= 1'b0;
                            r_state   <= S_LOAD;
                        end else begin
                            // r_pending is known clear on this path.
                            r_pending <= reseed_req;
                            lfsr_en   <= 1'b1;
                            r_state   <= S_FILL;
                        end
                    end else begin
                        r_pending <= r_pending | reseed_req;
                    end
                end

                default: begin
                    r_state          <= S_IDLE;
                    r_cnt            <= '0;
                    r_pending        <= 1'b0;
                    lfsr_load        <= 1'b0;
                    lfsr_en          <= 1'b0;
                    busy             <= 1'b0;
                    word.word_valid  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lfsr_keystream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lfsr_keystream_ctrl
//  Description : Bench for lfsr_keystream_ctrl. Provides a 16-bit LFSR
//                behind the controller, a transaction-level reference model
//                feeding an expected-word queue, a monitor that checks each
//                presented word, and directed plus random stimulus.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lfsr_keystream_ctrl;

    localparam int WIDTH  = 8;
    localparam int SEED_W = 16;
    localparam int WARMUP = 32;
    localparam int PERIOD = 4;

    logic              clk        = 1'b0;
    logic              rst        = 1'b0;
    logic              start      = 1'b0;
    logic              stop       = 1'b0;
    logic              reseed_req = 1'b0;
    logic [SEED_W-1:0] seed       = '0;
    logic              lfsr_load;
    logic [SEED_W-1:0] lfsr_seed;
    logic              lfsr_en;
    logic              lfsr_bit;
    logic              busy;
    logic [15:0]       word_count;

    lfsr_keystream_ctrl_if #(.WIDTH(WIDTH)) wif ();

    always #5 clk = ~clk;

    lfsr_keystream_ctrl #(
        .WIDTH         (WIDTH),
        .SEED_W        (SEED_W),
        .WARMUP        (WARMUP),
        .RESEED_PERIOD (PERIOD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .seed       (seed),
        .reseed_req (reseed_req),
        .lfsr_load  (lfsr_load),
        .lfsr_seed  (lfsr_seed),
        .lfsr_en    (lfsr_en),
        .lfsr_bit   (lfsr_bit),
        .busy       (busy),
        .word_count (word_count),
        .word       (wif)
    );

    // ------------------------------------------------------------------
    // LFSR that the controller drives (x^16 + x^14 + x^13 + x^11 + 1).
    // ------------------------------------------------------------------
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    logic [15:0] env_state = '0;
    always @(posedge clk) begin
        if (lfsr_load)    env_state <= lfsr_seed;
        else if (lfsr_en) env_state <= lfsr_step(env_state);
    end
    assign lfsr_bit = env_state[0];

    // ------------------------------------------------------------------
    // Check bookkeeping
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    endtask

    // ------------------------------------------------------------------
    // Reference model (transaction level). Each cycle it looks at what
    // the DUT will sample at the coming edge and decides which keystream
    // word must be presented next and with which word_count.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] exp_q[$];
    logic [15:0]      exp_cnt_q[$];
    logic [15:0]      m_lfsr;
    bit               m_run     = 1'b0;
    bit               m_pend    = 1'b0;
    bit               m_loadcyc = 1'b0;
    int               m_period  = 0;
    logic [15:0]      m_count   = '0;

    function automatic void m_new_stream(input logic [15:0] s);
        m_lfsr = (s == 16'h0) ? 16'h1 : s;
        for (int i = 0; i < WARMUP; i++) m_lfsr = lfsr_step(m_lfsr);
    endfunction

    function automatic void m_push();
        logic [WIDTH-1:0] w;
        w = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w      = (w << 1) | WIDTH'(m_lfsr[0]);
            m_lfsr = lfsr_step(m_lfsr);
        end
        exp_q.push_back(w);
        exp_cnt_q.push_back(m_count);
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            m_run = 0; m_pend = 0; m_loadcyc = 0; m_period = 0; m_count = '0;
            exp_q.delete(); exp_cnt_q.delete();
        end else if (!m_run) begin
            if (start) begin
                m_run = 1; m_pend = 0; m_period = 0; m_loadcyc = 1;
                m_new_stream(seed);
                m_push();
            end
        end else if (stop) begin
            m_run = 0; m_pend = 0; m_loadcyc = 0;
            exp_q.delete(); exp_cnt_q.delete();
        end else if (m_loadcyc) begin
            m_loadcyc = 0;            // a request during the load is absorbed
        end else if (wif.word_valid && wif.word_ready) begin
            m_count++;
            m_period++;
            if (m_pend || (PERIOD != 0 && m_period == PERIOD)) begin
                m_new_stream(seed);
                m_pend = 0; m_period = 0; m_loadcyc = 1;
            end else begin
                m_pend = reseed_req;
            end
            m_push();
        end else if (reseed_req) begin
            m_pend = 1;
        end
    end

    // ------------------------------------------------------------------
    // Monitor: pops one expectation per presented word; checks that held
    // words stay stable with the LFSR stopped.
    // ------------------------------------------------------------------
    logic             prev_valid = 1'b0;
    logic [WIDTH-1:0] prev_data  = '0;
    int               age        = 0;

    always @(posedge clk) begin
        #1;
        check("en_load_exclusive", longint'(lfsr_en & lfsr_load), 0);
        if (wif.word_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", 1, 0);
            end else begin
                check("word_data", wif.word_data, exp_q.pop_front());
                check("word_count", word_count, exp_cnt_q.pop_front());
            end
            age = 0;
        end else if (wif.word_valid) begin
            check("hold_data", wif.word_data, prev_data);
            check("hold_lfsr_en", longint'(lfsr_en), 0);
        end
        if (exp_q.size() > 0 && !wif.word_valid) begin
            age++;
            if (age > WARMUP + WIDTH + 8) begin
                check("word_timeout", age, WARMUP + WIDTH + 8);
                exp_q.delete(); exp_cnt_q.delete();
                age = 0;
            end
        end else if (exp_q.size() == 0) begin
            age = 0;
        end
        prev_valid = wif.word_valid;
        prev_data  = wif.word_data;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs always change 2 ns after a rising edge.
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic wait_valid(input int limit, output bit seen);
        seen = 0;
        for (int k = 0; k < limit && !seen; k++) begin
            @(negedge clk);
            if (wif.word_valid) seen = 1;
        end
    endtask

    int          n_load, load_at, n_en, rise_at, hs, loads, l1, l2, rises;
    logic [15:0] ld_seed, cnt0;
    logic [WIDTH-1:0] d0;
    bit          seen, got;

    initial begin
        wif.word_ready = 1'b0;

        // ---------------- reset with random inputs ----------------
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start = 1'($urandom); stop = 1'($urandom); reseed_req = 1'($urandom);
            seed = 16'($urandom); wif.word_ready = 1'($urandom);
            tick();
        end
        @(negedge clk);
        check("rst_lfsr_load", lfsr_load, 0);
        check("rst_lfsr_en", lfsr_en, 0);
        check("rst_lfsr_seed", lfsr_seed, 0);
        check("rst_word_data", wif.word_data, 0);
        check("rst_word_valid", wif.word_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_word_count", word_count, 0);
        tick();
        start = 0; stop = 0; reseed_req = 0; wif.word_ready = 0; rst = 1'b1;
        tick();
        @(negedge clk);
        check("idle_no_load", lfsr_load, 0);
        check("idle_busy", busy, 0);

        // ---------------- start with defaults ----------------
        tick();
        wif.word_ready = 1; seed = 16'hACE1; start = 1;
        tick();                                   // E0
        start = 0;
        n_load = 0; load_at = -1; n_en = 0; rise_at = -1; ld_seed = '0;
        for (int k = 0; k < 60 && rise_at < 0; k++) begin
            @(negedge clk);
            if (lfsr_load) begin n_load++; load_at = k; ld_seed = lfsr_seed; end
            if (lfsr_en) n_en++;
            if (wif.word_valid) rise_at = k;
            if (k == 0) check("start_busy", busy, 1);
        end
        check("start_load_count", n_load, 1);
        check("start_load_cycle", load_at, 0);
        check("start_seed", ld_seed, 16'hACE1);
        check("start_en_cycles", n_en, WARMUP + WIDTH);
        check("start_valid_latency", rise_at, WARMUP + WIDTH + 1);
        @(negedge clk);
        check("start_count_after_hs", word_count, 1);
        check("start_valid_drop", wif.word_valid, 0);

        // ---------------- backpressure ----------------
        tick(); stop = 1; tick(); stop = 0;
        wif.word_ready = 0; seed = 16'($urandom); start = 1;
        tick(); start = 0;
        wait_valid(100, seen);
        check("bp_valid_seen", seen, 1);
        cnt0 = word_count; d0 = wif.word_data;
        repeat (20) @(negedge clk);
        check("bp_data_stable", wif.word_data, d0);
        check("bp_count_stable", word_count, cnt0);
        check("bp_lfsr_en", lfsr_en, 0);
        check("bp_valid_held", wif.word_valid, 1);
        tick(); wif.word_ready = 1; tick(); wif.word_ready = 0;
        @(negedge clk);
        check("bp_count_inc", word_count, cnt0 + 16'd1);

        // ---------------- stop in HOLD with coincident ready ----------------
        wait_valid(100, seen);
        check("stop_valid_seen", seen, 1);
        cnt0 = word_count;
        tick(); stop = 1; wif.word_ready = 1; tick(); stop = 0; wif.word_ready = 0;
        @(negedge clk);
        check("stop_count", word_count, cnt0);
        check("stop_valid", wif.word_valid, 0);
        check("stop_busy", busy, 0);

        // ---------------- zero seed, clean restart ----------------
        tick(); seed = 16'h0; start = 1; tick(); start = 0;
        @(negedge clk);
        check("zero_seed_load", lfsr_load, 1);
        check("zero_seed_value", lfsr_seed, 16'h0001);

        // ---------------- requested reseed ----------------
        tick(); stop = 1; tick(); stop = 0;
        seed = 16'hBEEF; wif.word_ready = 1; start = 1; tick(); start = 0;
        wait_valid(100, seen);
        check("rs_first_word", seen, 1);
        tick();                                   // handshake edge, now filling word 2
        seed = 16'h1234; reseed_req = 1; tick(); reseed_req = 0;
        got = 0; rises = 0; ld_seed = '0;
        for (int k = 0; k < 80 && !got; k++) begin
            @(negedge clk);
            if (lfsr_load) begin got = 1; ld_seed = lfsr_seed; end
            else if (wif.word_valid) rises++;
        end
        check("rs_load_seen", got, 1);
        check("rs_load_seed", ld_seed, 16'h1234);
        check("rs_words_before_load", rises, 1);
        n_en = 0; rise_at = -1;
        for (int k = 1; k < 60 && rise_at < 0; k++) begin
            @(negedge clk);
            if (lfsr_en) n_en++;
            if (wif.word_valid) rise_at = k;
        end
        check("rs_en_cycles", n_en, WARMUP + WIDTH);
        check("rs_valid_latency", rise_at, WARMUP + WIDTH + 1);

        // ---------------- periodic reseed ----------------
        hs = 0; loads = 0; l1 = -1; l2 = -1;
        for (int k = 0; k < 400 && loads < 2; k++) begin
            if (k > 0) @(negedge clk);
            if (lfsr_load) begin
                loads++;
                if (loads == 1) l1 = hs; else l2 = hs;
            end
            if (wif.word_valid && wif.word_ready) hs++;
        end
        check("per_loads", loads, 2);
        check("per_first_load_hs", l1, PERIOD);
        check("per_second_load_hs", l2, 2 * PERIOD);

        // ---------------- random traffic ----------------
        tick();
        for (int i = 0; i < 4000; i++) begin
            wif.word_ready = ($urandom_range(0, 9) < 7);
            reseed_req     = ($urandom_range(0, 49) == 0);
            seed           = 16'($urandom);
            start          = ($urandom_range(0, 9) == 0);
            stop           = ($urandom_range(0, 299) == 0);
            rst            = !($urandom_range(0, 999) == 0);
            tick();
        end
        rst = 1; start = 0; stop = 0; reseed_req = 0; wif.word_ready = 1;
        repeat (100) tick();
        stop = 1; tick(); stop = 0;
        repeat (3) tick();
        @(negedge clk);
        check("end_idle", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lfsr_keystream_ctrl.md
# lfsr_keystream_ctrl

Sequencing controller for the project's LFSR keystream generator. It seeds the LFSR, runs a discard warm-up, and packs the serial LFSR output into WIDTH-bit words. Words go to a downstream consumer (scrambler, chaotic-map mixer) over a valid/ready handshake. It also schedules reseeds, either on request or periodically. The LFSR itself stays a separate instance; this block drives its load and enable controls and samples its output bit.

## Interface
Parameters:
- WIDTH, 8: bits per output word (≥1)
- SEED_W, 16: LFSR state/seed width
- WARMUP, 32: LFSR steps discarded after every load (0 allowed)
- RESEED_PERIOD, 1024: words between automatic reseeds; 0 disables

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- start  in  1  begin operation; sampled only in IDLE
- stop  in  1  abort to IDLE from any state
- seed  in  SEED_W  seed value; sampled on start and on reseed
- reseed_req  in  1  single-cycle reseed request
- lfsr_load  out  1  one-cycle parallel-load strobe to LFSR
- lfsr_seed  out  SEED_W  value to load
- lfsr_en  out  1  LFSR advance enable
- lfsr_bit  in  1  current LFSR output bit
- word_data  out  WIDTH  packed keystream word
- word_valid  out  1  word_data valid
- word_ready  in  1  consumer accepts word
- busy  out  1  state != IDLE
- word_count  out  16  accepted words since reset, wraps at 0xFFFF→0

## Operation
- LFSR contract: when lfsr_en=1, the controller captures lfsr_bit at the edge, and the LFSR advances at that same edge. When lfsr_load=1, the LFSR takes lfsr_seed at the edge. The controller never asserts lfsr_en and lfsr_load together.

- FSM states are IDLE, LOAD, WARMUP, FILL and HOLD.
  - **IDLE:** outputs are inactive. On start=1, latch seed and go to LOAD. A seed of 0 is replaced by 1, so the LFSR never gets the all-zero lock-up state.
  - **LOAD:** lfsr_load=1 for exactly one cycle, with lfsr_seed equal to the latched seed. The reseed-pending flag and the period counter clear here. Next state is WARMUP, or FILL if WARMUP=0.
  - **WARMUP:** lfsr_en=1 for exactly WARMUP cycles. Captured bits are discarded. Then go to FILL.
  - **FILL:** lfsr_en=1 for exactly WIDTH cycles. Bits shift in MSB-first, so the first captured bit ends in word_data[WIDTH-1]. After the last bit, word_data is registered, word_valid goes to 1, and the state moves to HOLD.
  - **HOLD:** lfsr_en=0. word_data and word_valid are held stable until word_ready=1. The handshake is word_valid & word_ready at an edge. On handshake:
    - word_count increments by 1.
    - The period counter increments.
    - If reseed is pending, or the period counter reaches RESEED_PERIOD (when RESEED_PERIOD≠0), latch seed (0→1) and go to LOAD.
    - Otherwise go to FILL.
  - word_valid deasserts on the cycle after the handshake.
- reseed_req sets a sticky pending flag in any non-IDLE state and is ignored in IDLE. A pending reseed never truncates a word in progress; it is honoured only at the next HOLD handshake. If reseed_req arrives during LOAD or WARMUP, the flag is cleared at the next LOAD entry only if that LOAD is already in progress; otherwise it is kept.
- start outside IDLE is ignored. If start and reseed_req arrive together in IDLE, start is honoured and reseed_req is ignored.
- stop=1 in any non-IDLE state forces the next state to IDLE.
  - word_valid, lfsr_en and lfsr_load go to 0 on the next cycle.
  - A held word is discarded and not counted; the pending flag clears.
  - stop takes priority over a simultaneous handshake: the word is not counted.
- Reset (rst=0 at an edge): state IDLE; all outputs 0 (word_data, lfsr_seed, word_count, word_valid, lfsr_en, lfsr_load, busy); pending flag and counters cleared. Reset applied mid-operation behaves identically.

## Timing
- Let E0 be the edge where start is sampled.
  - lfsr_load is high in the cycle after E0.
  - lfsr_en is high for WARMUP+WIDTH consecutive cycles starting at E1.
  - word_valid rises after edge E(WARMUP+WIDTH+1), which is 41 edges with the defaults.
- Steady state with word_ready held at 1: one word every WIDTH+1 cycles (WIDTH fill cycles plus one HOLD cycle).
- Reseed overhead: 1 + WARMUP extra cycles before the next FILL.
- busy is registered from the state, so it goes to 1 the cycle after E0.

## Test plan
- **Reset:** hold rst=0 for 3 cycles with random inputs → every output is 0 and busy=0; release → state stays IDLE with no lfsr_load.
- **Start, defaults:** seed=0xACE1, word_ready=1 → exactly one lfsr_load with lfsr_seed=0xACE1; lfsr_en high for 40 cycles; word_valid rises 41 edges after start; word_data equals LFSR bits 33..40 of a reference model, MSB-first; word_count=1 after the handshake.
- **Backpressure:** word_ready=0 for 20 cycles while word_valid=1 → word_data stable, lfsr_en=0, word_count unchanged; raising word_ready gives exactly one increment.
- **Zero seed:** start with seed=0 → lfsr_seed=0x0001.
- **Reseed:** pulse reseed_req during FILL with seed=0x1234 → the current word completes; after its handshake, lfsr_load with 0x1234 and then a 32-cycle warm-up. With RESEED_PERIOD=4 and no request → a load after every 4th handshake.
- **Stop:** stop in HOLD coincident with word_ready=1 → word_count unchanged; word_valid=0 and busy=0 on the next cycle; a later start reloads cleanly.
